// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush, memory freeze and stall counting for a 5-stage pipeline
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             br_taken_i,
  input  logic             mem_busy_i,
  input  logic             clr_cnt_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             pipe_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ld_haz_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {RUN, BUBBLE, LDFWD} state_t;
  state_t           state_q, state_d;
  logic             ld_haz_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  // hazard detection, enables, flushes and next-state; BUBBLE holds a bubble in EX so no load-use can be seen there
  always_comb begin
    lu = ex_memread_i && (|ex_rd_i) && state_q != BUBBLE &&
         ((ex_rd_i == id_rs1_i && id_rs1_used_i) || (ex_rd_i == id_rs2_i && id_rs2_used_i));
    pc_we_o       = rst_ni && !mem_busy_i && (br_taken_i || !lu);
    if_id_we_o    = pc_we_o;
    pipe_we_o     = rst_ni && !mem_busy_i;
    if_id_flush_o = !rst_ni || (!mem_busy_i && br_taken_i);
    id_ex_flush_o = !rst_ni || (!mem_busy_i && (br_taken_i || lu));
    state_d       = mem_busy_i ? state_q :
                    state_q == BUBBLE ? LDFWD :
                    (lu && !br_taken_i) ? BUBBLE : RUN;
    cnt_d         = clr_cnt_i ? '0 : (!pc_we_o && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, registered forwarding pulse and saturating stall counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      ld_haz_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_haz_q <= state_d == LDFWD;
      cnt_q    <= cnt_d;
    end
  end
  assign ld_haz_o    = ld_haz_q;
  assign stall_cnt_o = cnt_q;
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall performance counter; legal range 8..32.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 ID_RS1, ID_RS2  in  5 each  source register addresses of the instruction in ID.
REQ-005 ID_RS1_USED, ID_RS2_USED  in  1 each  ID instruction actually reads RS1/RS2.
REQ-006 EX_RD  in  5  destination register of the instruction in EX.
REQ-007 EX_MEMREAD  in  1  EX instruction is a load.
REQ-008 BR_TAKEN  in  1  branch/jump in EX resolved as redirecting the PC.
REQ-009 MEM_BUSY  in  1  data memory not ready; pipeline must freeze.
REQ-010 CLR_CNT  in  1  synchronous clear of STALL_CNT.
REQ-011 PC_WE, IF_ID_WE  out  1 each  write enables for the PC and the IF/ID register.
REQ-012 PIPE_WE  out  1  common write enable for the ID/EX, EX/MEM and MEM/WB registers.
REQ-013 IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a bubble into IF/ID and ID/EX on the next edge.
REQ-014 LD_HAZ  out  1  load result in WB must be forwarded to the consumer now in EX; feeds the forwarding unit.
REQ-015 STALL_CNT  out  CNT_W  count of cycles in which PC_WE was 0.

Function
REQ-016 Load-use detection (LU) SHALL be EX_MEMREAD && EX_RD!=0 && ((EX_RD==ID_RS1 && ID_RS1_USED) || (EX_RD==ID_RS2 && ID_RS2_USED)).
REQ-017 FSM states SHALL be RUN, BUBBLE and LDFWD; the encoding is free.
REQ-018 Priority each cycle SHALL be MEM_BUSY > BR_TAKEN > LU > normal.
REQ-019 MEM_BUSY=1: PC_WE=IF_ID_WE=PIPE_WE=0, both flushes 0; state and LD_HAZ hold; BR_TAKEN and LU are ignored.
REQ-020 BR_TAKEN=1 (not busy): PC_WE=IF_ID_WE=PIPE_WE=1, IF_ID_FLUSH=ID_EX_FLUSH=1; LU is suppressed because the ID instruction is squashed.
REQ-021 LU=1 (not busy, no branch): PC_WE=IF_ID_WE=0, PIPE_WE=1, ID_EX_FLUSH=1, IF_ID_FLUSH=0; next state BUBBLE.
REQ-022 Normal cycle: PC_WE=IF_ID_WE=PIPE_WE=1, flushes 0.
REQ-023 RUN: goes to BUBBLE on LU (per REQ-021); otherwise stays in RUN.
REQ-024 BUBBLE: the stalled consumer is still in ID and the load is in MEM; outputs per REQ-022; next state LDFWD.
REQ-025 LDFWD: LD_HAZ=1 for exactly this cycle (consumer in EX, load in WB); next state BUBBLE on LU, else RUN.
REQ-026 LDFWD with BR_TAKEN: the flush applies; LD_HAZ stays 1 because the load is older than the branch.
REQ-027 LD_HAZ SHALL be a registered state decode, glitch-free, and 0 in every state except LDFWD.
REQ-028 All other outputs SHALL be combinational from the current state and the inputs, with no combinational loops.
REQ-029 STALL_CNT increments on every edge where PC_WE==0 and saturates at 2^CNT_W-1.
REQ-030 CLR_CNT has priority over increment; the cleared value is 0 on the next edge.
REQ-031 Back-to-back load-use sequences SHALL yield exactly one bubble each, with no lost or duplicate LD_HAZ pulses.

Reset
REQ-032 RST_N low SHALL immediately force state=RUN, LD_HAZ=0, STALL_CNT=0, PC_WE=IF_ID_WE=PIPE_WE=0 and IF_ID_FLUSH=ID_EX_FLUSH=1.
REQ-033 The first rising CLK edge with RST_N high resumes normal operation; reset asserted mid-stall aborts the pending LD_HAZ pulse.

Verification
REQ-034 LU stall: EX_MEMREAD=1, EX_RD=5, ID_RS1=5, RS1_USED=1 at cycle t -> at t: PC_WE=0, ID_EX_FLUSH=1; t+1: normal; t+2: LD_HAZ=1; t+3: LD_HAZ=0; STALL_CNT+=1.
REQ-035 No-stall cases: EX_RD=0 or RS1_USED=0 or EX_MEMREAD=0 with matching addresses -> PC_WE=1, no flush, LD_HAZ never 1.
REQ-036 Freeze: MEM_BUSY=1 for 3 cycles in BUBBLE -> all WEs 0, state held, LD_HAZ asserted only 1 cycle after MEM_BUSY drops, STALL_CNT+=3.
REQ-037 Branch vs LU: BR_TAKEN=1 and LU=1 in the same cycle -> both flushes 1, PC_WE=1, state stays RUN.
REQ-038 Saturation and reset: CNT_W=8, force 300 stall cycles -> STALL_CNT=255; pulse CLR_CNT -> 0; drop RST_N in BUBBLE -> LD_HAZ stays 0 after release.
